fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_pc_next.sv | 15 +
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch state enum, address widths and the default reset PC.
package fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned WADDR_W = 29;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SPLIT = 2'd2
  } fetch_state_e;

  // 64-bit SRAM word index of a byte address.
  function automatic logic [WADDR_W-1:0] word_of(input logic [PC_W-1:0] addr);
    return addr[PC_W-1:3];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: redirect/decode handshake in, SRAM strobe and decode view out.
// master = fetch controller, slave = decoder/SRAM/redirect side.
interface fetch_ctrl_if import fetch_pkg::*; ();

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               dec_ready;
  logic               isrv16;
  logic               sram_cs;
  logic [WADDR_W-1:0] sram_addr;
  logic [PC_W-1:0]    pc;
  logic               instr_valid;
  logic               hold_h;
  logic               split_sel;
  logic [31:0]        stall_cnt;

  modport master (
    input  redirect, redirect_pc, dec_ready, isrv16,
    output sram_cs, sram_addr, pc, instr_valid, hold_h, split_sel, stall_cnt
  );

  modport slave (
    output redirect, redirect_pc, dec_ready, isrv16,
    input  sram_cs, sram_addr, pc, instr_valid, hold_h, split_sel, stall_cnt
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Sequential PC increment: next PC by instruction size and whether it leaves
// the current 64-bit SRAM word.
module fetch_pc_next import fetch_pkg::*; (
  input  logic [PC_W-1:0] pc,
  input  logic            isrv16,
  output logic [PC_W-1:0] pc_next,
  output logic            word_cross
);

  always_comb begin
    pc_next    = pc + (isrv16 ? PC_W'(2) : PC_W'(4));
    word_cross = (word_of(pc_next) != word_of(pc));
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: tracks the decode PC, strobes the 64-bit SRAM,
// and stitches 32-bit instructions that straddle two SRAM words.
module fetch_ctrl import fetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.master  bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               split_done_q, split_done_d;
  logic               boot_q, boot_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  logic               inc_is16;
  logic [PC_W-1:0]    pc_inc;
  logic               inc_cross;

  logic               instr_valid;
  logic               hold_h;
  logic               split_sel;
  logic               sram_cs;
  logic [WADDR_W-1:0] sram_addr;
  logic               unused_rpc0;

  // The second half of a split instruction is always a +4 step.
  always_comb begin
    inc_is16 = (state_q == ST_SPLIT) ? 1'b0 : bus.isrv16;
  end

  fetch_pc_next u_pc_next (
    .pc         (pc_q),
    .isrv16     (inc_is16),
    .pc_next    (pc_inc),
    .word_cross (inc_cross)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    split_done_d = split_done_q;
    boot_d       = 1'b0;
    instr_valid  = 1'b0;
    hold_h       = 1'b0;
    split_sel    = 1'b0;
    sram_cs      = 1'b0;
    sram_addr    = word_of(pc_q);
    unused_rpc0  = bus.redirect_pc[0];

    unique case (state_q)
      ST_FILL: begin
        // First cycle out of reset issues the initial read and waits for its data.
        if (boot_q) begin
          sram_cs = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if ((pc_q[2:1] == 2'b11) && !bus.isrv16 && !split_done_q) begin
          hold_h    = 1'b1;
          sram_cs   = 1'b1;
          sram_addr = word_of(pc_q) + WADDR_W'(1);
          state_d   = ST_SPLIT;
        end else begin
          instr_valid = 1'b1;
          if (bus.dec_ready) begin
            pc_d = pc_inc;
            if (inc_cross) begin
              sram_cs   = 1'b1;
              sram_addr = word_of(pc_inc);
            end
          end
        end
      end

      ST_SPLIT: begin
        instr_valid  = 1'b1;
        split_sel    = 1'b1;
        split_done_d = 1'b1;
        if (bus.dec_ready) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (pc_d != pc_q) begin
      split_done_d = 1'b0;
    end

    // Redirect wins over accept, increment and any split in progress.
    if (bus.redirect) begin
      pc_d         = {bus.redirect_pc[PC_W-1:1], 1'b0};
      sram_cs      = 1'b1;
      sram_addr    = word_of(bus.redirect_pc);
      hold_h       = 1'b0;
      split_done_d = 1'b0;
      state_d      = ST_FILL;
    end

    stall_cnt_d = stall_cnt_q + {31'd0, ~instr_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      pc_q         <= RESET_PC;
      split_done_q <= 1'b0;
      boot_q       <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      split_done_q <= split_done_d;
      boot_q       <= boot_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // boot_q is already set while reset is held; gating keeps the strobe quiet until release.
  always_comb begin
    bus.sram_cs     = sram_cs & rst_n;
    bus.sram_addr   = sram_addr;
    bus.pc          = pc_q;
    bus.instr_valid = instr_valid;
    bus.hold_h      = hold_h;
    bus.split_sel   = split_sel;
    bus.stall_cnt   = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(hold_h && split_sel));
      assert (!split_sel || (state_q == ST_SPLIT));
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table through a scoreboard queue,
// plus a hand-written reset-during-split sequence.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;

  fetch_ctrl_if bus_if ();

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        is16;
    logic        valid;
    logic [31:0] pc;
    logic        cs;
    logic [28:0] addr;
    logic        hold;
    logic        split;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int unsigned total;
  int unsigned passed;
  int unsigned stall_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy, input logic is16,
                     input logic valid, input logic [31:0] pc, input logic cs, input logic [28:0] addr,
                     input logic hold, input logic split);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.is16 = is16;
    v.valid = valid; v.pc = pc; v.cs = cs; v.addr = addr; v.hold = hold; v.split = split;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy, input logic is16);
    bus_if.redirect    = redir;
    bus_if.redirect_pc = rpc;
    bus_if.dec_ready   = rdy;
    bus_if.isrv16      = is16;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    total = 0; passed = 0; stall_exp = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    //   redir rpc          rdy is16  valid pc          cs  addr          hold split
    add(0, 32'h0,        0, 1,     0, 32'h100,      1, 29'h20,       0, 0); // boot read
    add(0, 32'h0,        0, 1,     0, 32'h100,      0, 29'h0,        0, 0); // fill
    add(0, 32'h0,        1, 1,     1, 32'h100,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 1,     1, 32'h102,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 1,     1, 32'h104,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 1,     1, 32'h106,      1, 29'h21,       0, 0); // zero-bubble refetch
    add(0, 32'h0,        1, 0,     1, 32'h108,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 1,     1, 32'h10C,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 0,     0, 32'h10E,      1, 29'h22,       1, 0); // split start
    add(0, 32'h0,        0, 0,     1, 32'h10E,      0, 29'h0,        0, 1); // split held
    add(0, 32'h0,        1, 0,     1, 32'h10E,      0, 29'h0,        0, 1);
    add(0, 32'h0,        1, 1,     1, 32'h112,      0, 29'h0,        0, 0);
    add(1, 32'h2003,     1, 1,     1, 32'h114,      1, 29'h400,      0, 0); // redirect beats accept
    add(0, 32'h0,        1, 1,     0, 32'h2002,     0, 29'h0,        0, 0);
    add(1, 32'h106,      1, 1,     1, 32'h2002,     1, 29'h20,       0, 0);
    add(0, 32'h0,        1, 0,     0, 32'h106,      0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 0,     0, 32'h106,      1, 29'h21,       1, 0);
    add(1, 32'h40,       1, 0,     1, 32'h106,      1, 29'h8,        0, 1); // redirect in split
    add(0, 32'h0,        1, 0,     0, 32'h40,       0, 29'h0,        0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0,      0, 0,     1, 32'h40,       0, 29'h0,        0, 0); // decoder stalled
    add(0, 32'h0,        1, 0,     1, 32'h40,       0, 29'h0,        0, 0);
    add(0, 32'h0,        1, 0,     1, 32'h44,       1, 29'h9,        0, 0);
    add(1, 32'hFFFF_FFFC, 1, 1,    1, 32'h48,       1, 29'h1FFF_FFFF, 0, 0);
    add(0, 32'h0,        0, 0,     0, 32'hFFFF_FFFC, 0, 29'h0,       0, 0);
    add(0, 32'h0,        1, 0,     1, 32'hFFFF_FFFC, 1, 29'h0,       0, 0); // pc wraps to 0
    add(1, 32'hFFFF_FFFF, 0, 1,    1, 32'h0,        1, 29'h1FFF_FFFF, 0, 0);
    add(0, 32'h0,        1, 1,     0, 32'hFFFF_FFFE, 0, 29'h0,       0, 0);
    add(0, 32'h0,        1, 0,     0, 32'hFFFF_FFFE, 1, 29'h0,       1, 0); // split word index wraps
    add(0, 32'h0,        1, 0,     1, 32'hFFFF_FFFE, 0, 29'h0,       0, 1);
    add(0, 32'h0,        0, 1,     1, 32'h2,        0, 29'h0,        0, 0);

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("reset sram_cs", {31'd0, bus_if.sram_cs}, 32'd0);
    chk("reset instr_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("reset hold_h", {31'd0, bus_if.hold_h}, 32'd0);
    chk("reset split_sel", {31'd0, bus_if.split_sel}, 32'd0);
    chk("reset pc", bus_if.pc, 32'h100);
    chk("reset stall_cnt", bus_if.stall_cnt, 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].is16);
      sb.push_back(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk($sformatf("r%0d scoreboard empty", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("r%0d instr_valid", i), {31'd0, bus_if.instr_valid}, {31'd0, e.valid});
        chk($sformatf("r%0d pc", i), bus_if.pc, e.pc);
        chk($sformatf("r%0d sram_cs", i), {31'd0, bus_if.sram_cs}, {31'd0, e.cs});
        if (e.cs) chk($sformatf("r%0d sram_addr", i), {3'd0, bus_if.sram_addr}, {3'd0, e.addr});
        chk($sformatf("r%0d hold_h", i), {31'd0, bus_if.hold_h}, {31'd0, e.hold});
        chk($sformatf("r%0d split_sel", i), {31'd0, bus_if.split_sel}, {31'd0, e.split});
        chk($sformatf("r%0d stall_cnt", i), bus_if.stall_cnt, stall_exp);
        if (!e.valid) stall_exp++;
      end
    end

    // Reset asserted while a split is in flight.
    @(posedge clk); #1; drive(1'b1, 32'h106, 1'b0, 1'b0);
    @(posedge clk); #1; drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midsplit split_sel", {31'd0, bus_if.split_sel}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midsplit rst split_sel", {31'd0, bus_if.split_sel}, 32'd0);
    chk("midsplit rst instr_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("midsplit rst sram_cs", {31'd0, bus_if.sram_cs}, 32'd0);
    chk("midsplit rst hold_h", {31'd0, bus_if.hold_h}, 32'd0);
    chk("midsplit rst pc", bus_if.pc, 32'h100);
    chk("midsplit rst stall_cnt", bus_if.stall_cnt, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("reboot sram_cs", {31'd0, bus_if.sram_cs}, 32'd1);
    chk("reboot sram_addr", {3'd0, bus_if.sram_addr}, 32'h20);
    @(negedge clk);
    chk("reboot fill instr_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    @(negedge clk);
    chk("reboot run instr_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    chk("reboot run pc", bus_if.pc, 32'h100);
    chk("reboot stall_cnt", bus_if.stall_cnt, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
